// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e    : FSM state encoding (IDLE=0, WAIT=1, RESP=2)
//   CNT_W      : width of the read wait-state counter
//   RD_LAT_MAX : largest wait-state count the counter can hold
//   MMIO_ADDR  : all-ones address (sliced down to ADDR_W by users) that selects
//                the MMIO register when DMEM_MMIO_EN is defined
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CNT_W      = 4;
  localparam int RD_LAT_MAX = (1 << CNT_W) - 1;

  localparam logic [31:0] MMIO_ADDR = '1;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the datapath (master) and the data-memory
// responder (slave).
//   req, we, addr, wdata : master -> slave, held stable until ack
//   rdata, ack, busy     : slave -> master
interface data_mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;

  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: synchronous write, registered read, no reset
// (contents survive a responder reset).
//   clk   : rising-edge clock
//   we    : write enable for waddr/wdata
//   waddr : write index
//   wdata : write data
//   raddr : read index, captured every edge
//   rdata : registered read data (mem[raddr] as of the last edge)
module dmem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-wide storage behind a req/ack handshake with a
// programmable number of read wait states.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   bus      : slave side of data_mem_responder_if (req/we/addr/wdata in,
//              rdata/ack/busy out)
//   mmio_out : MMIO output register
// Optional feature macro: DMEM_MMIO_EN -- the all-ones address becomes an MMIO
// register instead of array storage. Undefined: mmio_out is tied to 0.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_responder_if.slave bus,
  output logic [DATA_W-1:0] mmio_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  if (RD_LAT < 0 || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_chk
    $error("data_mem_responder: RD_LAT=%0d outside 0..%0d", RD_LAT, RD_LAT_MAX);
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              in_rng_now, in_rng_q;
  logic              mmio_now, mmio_q_sel;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_raddr;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] load_val;

  assign in_rng_now = ({1'b0, bus.addr} < DEPTH_L);
  assign in_rng_q   = ({1'b0, addr_q}   < DEPTH_L);

`ifdef DMEM_MMIO_EN
  localparam logic [ADDR_W-1:0] MMIO_A = MMIO_ADDR[ADDR_W-1:0];
  logic [DATA_W-1:0] mmio_q, mmio_d;

  assign mmio_now   = (bus.addr == MMIO_A);
  assign mmio_q_sel = (addr_q == MMIO_A);

  always_comb begin
    mmio_d = mmio_q;
    if (accept && bus.we && mmio_now) mmio_d = bus.wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mmio_q <= '0;
    else      mmio_q <= mmio_d;
  end

  assign mmio_out = mmio_q;
  assign load_val = mmio_q_sel ? mmio_q : (in_rng_q ? arr_rdata : '0);
`else
  assign mmio_now   = 1'b0;
  assign mmio_q_sel = 1'b0;
  assign mmio_out   = '0;
  assign load_val   = in_rng_q ? arr_rdata : '0;
`endif

  // Out-of-range and MMIO stores never touch the array.
  assign arr_we = accept && bus.we && in_rng_now && !mmio_now;

  // The array samples the live address on the accept edge and the latched
  // address afterwards, so its output is valid by RESP even when RD_LAT=0.
  assign arr_raddr = (state_q == ST_IDLE) ? bus.addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (bus.addr[IDX_W-1:0]),
    .wdata (bus.wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  // Loads always pass through WAIT (even with RD_LAT=0) so that load latency
  // is uniformly RD_LAT+2. ack/rdata are registered on the edge leaving RESP;
  // the ack cycle is therefore an IDLE cycle, and req is next sampled on the
  // edge that ends it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.req) begin
          accept = 1'b1;
          busy_d = 1'b1;
          addr_d = bus.addr;
          we_d   = bus.we;
          if (bus.we) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_W'(RD_LAT);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        ack_d   = 1'b1;
        state_d = ST_IDLE;
        if (!we_q) rdata_d = load_val;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;

endmodule
